// File: rtl/reaction_counter.sv
// Elapsed-time counter for the reaction-timer game: divides clk down to a tick rate and
// keeps a saturating 5-digit BCD count alongside a numerically identical binary count.
module reaction_counter #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int MAX_CNT = 99999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [19:0] count,
    output logic [19:0] count_binary,
    output logic        tick,
    output logic        sat
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [19:0]   MAX_BIN    = 20'(MAX_CNT);

    generate
        if (DIV < 2 || DIV * TICK_HZ != CLK_HZ || MAX_CNT < 0 || MAX_CNT > 99999) begin : g_bad_params
            $error("reaction_counter: CLK_HZ/TICK_HZ must be an integer >= 2 and MAX_CNT in 0..99999");
        end
    endgenerate

    logic [PW-1:0] presc;
    logic          wrap;
    logic          at_max;
    logic [19:0]   bcd_next;
    logic [19:0]   bin_next;

    assign wrap     = (presc == PRESC_LAST);
    assign at_max   = (count_binary == MAX_BIN);
    assign bin_next = count_binary + 20'd1;

    // Ripple-carry decimal increment: a 9 rolls to 0 and passes the carry up.
    always_comb begin
        logic carry;
        bcd_next = count;
        carry    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    bcd_next[4*i +: 4] = 4'd0;
                end else begin
                    bcd_next[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc        <= '0;
            count        <= '0;
            count_binary <= '0;
            tick         <= 1'b0;
            sat          <= 1'b0;
        end else if (clr) begin
            presc        <= '0;
            count        <= '0;
            count_binary <= '0;
            tick         <= 1'b0;
            sat          <= 1'b0;
        end else if (en) begin
            tick  <= wrap;
            presc <= wrap ? '0 : presc + 1'b1;
            if (wrap) begin
                if (at_max) begin
                    sat <= 1'b1;
                end else begin
                    count        <= bcd_next;
                    count_binary <= bin_next;
                    sat          <= (bin_next == MAX_BIN);
                end
            end
        end else begin
            tick <= 1'b0;
        end
    end
endmodule
